// File: rtl/writeback_unit_if.sv
// Write-back stage bus: ALU result, load stream, issue/scoreboard and register-bank write port.
// master drives the stage inputs (upstream pipeline); slave is the write-back unit.
interface writeback_unit_if #(parameter int DEPTH = 2);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          aluValid;
    logic [2:0]    aluDest;
    logic [15:0]   aluData;
    logic          aluStall;
    logic          ldValid;
    logic          ldReady;
    logic [2:0]    ldDest;
    logic [15:0]   ldData;
    logic          issueValid;
    logic [2:0]    issueDest;
    logic [7:0]    pending;
    logic [CW-1:0] fifoCount;
    logic          regWrite;
    logic [2:0]    reg3;
    logic [15:0]   dataToWrite;

    modport master (
        output aluValid, aluDest, aluData, ldValid, ldDest, ldData, issueValid, issueDest,
        input  aluStall, ldReady, pending, fifoCount, regWrite, reg3, dataToWrite
    );

    modport slave (
        input  aluValid, aluDest, aluData, ldValid, ldDest, ldData, issueValid, issueDest,
        output aluStall, ldReady, pending, fifoCount, regWrite, reg3, dataToWrite
    );
endinterface

// File: rtl/writeback_unit.sv
// Owns the register-bank write port: arbitrates ALU results and FIFO-buffered loads, 1 cycle to regWrite.
// Loads backpressure via ldReady (count-only); ALU is held by a one-cycle aluStall after STARVE_LIMIT wins.
module writeback_unit #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic             clock,
    input  logic             resetN,
    writeback_unit_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {SEL_NONE, SEL_ALU, SEL_LD} sel_e;

    logic [15:0]   mem_dat_q [DEPTH];
    logic [2:0]    mem_dest_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          stall_q, stall_d;
    logic [7:0]    pending_q, pending_d;
    logic          regwrite_q, regwrite_d;
    logic [2:0]    reg3_q, reg3_d;
    logic [15:0]   wdat_q, wdat_d;

    sel_e          sel;
    logic          ld_ready;
    logic          push;
    logic          pop;
    logic          fifo_nempty;

    always_comb begin
        ld_ready    = (count_q < CW'(DEPTH));
        fifo_nempty = (count_q != '0);
        push        = bus.ldValid && ld_ready;

        // A pending stall slot always goes to the load, whatever the ALU offers.
        if (stall_q && fifo_nempty)  sel = SEL_LD;
        else if (bus.aluValid)       sel = SEL_ALU;
        else if (fifo_nempty)        sel = SEL_LD;
        else                         sel = SEL_NONE;
        pop = (sel == SEL_LD);

        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q;
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (!push && pop) count_d = count_q - CW'(1);

        regwrite_d = (sel != SEL_NONE);
        reg3_d     = reg3_q;
        wdat_d     = wdat_q;
        if (sel == SEL_ALU) begin
            reg3_d = bus.aluDest;
            wdat_d = bus.aluData;
        end else if (sel == SEL_LD) begin
            reg3_d = mem_dest_q[rd_ptr_q];
            wdat_d = mem_dat_q[rd_ptr_q];
        end

        starve_d = starve_q;
        stall_d  = 1'b0;
        if (pop || !fifo_nempty) begin
            starve_d = '0;
        end else if (sel == SEL_ALU) begin
            if (starve_q == SW'(STARVE_LIMIT - 1)) begin
                starve_d = '0;
                stall_d  = 1'b1;
            end else begin
                starve_d = starve_q + SW'(1);
            end
        end

        // Set is applied after clear so a same-cycle reissue keeps the bit pending.
        pending_d = pending_q;
        if (sel != SEL_NONE) pending_d[reg3_d] = 1'b0;
        if (bus.issueValid)  pending_d[bus.issueDest] = 1'b1;
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            starve_q   <= '0;
            stall_q    <= 1'b0;
            pending_q  <= '0;
            regwrite_q <= 1'b0;
            reg3_q     <= '0;
            wdat_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            starve_q   <= starve_d;
            stall_q    <= stall_d;
            pending_q  <= pending_d;
            regwrite_q <= regwrite_d;
            reg3_q     <= reg3_d;
            wdat_q     <= wdat_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_dat_q[wr_ptr_q]  <= bus.ldData;
            mem_dest_q[wr_ptr_q] <= bus.ldDest;
        end
    end

    assign bus.aluStall    = stall_q;
    assign bus.ldReady     = ld_ready;
    assign bus.pending     = pending_q;
    assign bus.fifoCount   = count_q;
    assign bus.regWrite    = regwrite_q;
    assign bus.reg3        = reg3_q;
    assign bus.dataToWrite = wdat_q;
endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit with a negedge-commit register bank model.
module tb_writeback_unit;
    logic clock;
    logic resetN;
    int   total;
    int   bad;
    logic [15:0] rf [8];

    writeback_unit_if #(.DEPTH(2)) bus ();

    writeback_unit #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clock  (clock),
        .resetN (resetN),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (bus.regWrite) rf[bus.reg3] <= bus.dataToWrite;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.aluValid = 1'b0; bus.aluDest = '0; bus.aluData = '0;
        bus.ldValid = 1'b0; bus.ldDest = '0; bus.ldData = '0;
        bus.issueValid = 1'b0; bus.issueDest = '0;
    endtask

    task automatic test_reset();
        idle();
        resetN = 1'b1;
        #2;
        bus.aluValid = 1'b1; bus.aluDest = 3'd6; bus.aluData = 16'h1234;
        bus.ldValid = 1'b1; bus.ldDest = 3'd1; bus.ldData = 16'h5678;
        bus.issueValid = 1'b1; bus.issueDest = 3'd2;
        resetN = 1'b0;
        tick(); tick();
        total++; if (bus.regWrite !== 1'b0) begin bad++; $display("FAIL rst_we got=%0h exp=0", bus.regWrite); end
        total++; if (bus.pending !== 8'h00) begin bad++; $display("FAIL rst_pending got=%0h exp=0", bus.pending); end
        total++; if (bus.ldReady !== 1'b1) begin bad++; $display("FAIL rst_ldready got=%0h exp=1", bus.ldReady); end
        total++; if (bus.fifoCount !== 2'd0) begin bad++; $display("FAIL rst_count got=%0h exp=0", bus.fifoCount); end
        total++; if (bus.aluStall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%0h exp=0", bus.aluStall); end
        total++; if ({bus.reg3, bus.dataToWrite} !== 19'h0) begin bad++; $display("FAIL rst_wport got=%0h/%0h exp=0/0", bus.reg3, bus.dataToWrite); end
        idle();
        resetN = 1'b1;
        tick();
        total++; if (bus.regWrite !== 1'b0) begin bad++; $display("FAIL rst_release_we got=%0h exp=0", bus.regWrite); end
    endtask

    task automatic test_alu();
        bus.aluValid = 1'b1; bus.aluDest = 3'd5; bus.aluData = 16'hBEEF;
        tick();
        bus.aluValid = 1'b0;
        total++; if (bus.regWrite !== 1'b1) begin bad++; $display("FAIL alu_we got=%0h exp=1", bus.regWrite); end
        total++; if (bus.reg3 !== 3'd5) begin bad++; $display("FAIL alu_dest got=%0h exp=5", bus.reg3); end
        total++; if (bus.dataToWrite !== 16'hBEEF) begin bad++; $display("FAIL alu_data got=%0h exp=beef", bus.dataToWrite); end
        tick();
        total++; if (rf[5] !== 16'hBEEF) begin bad++; $display("FAIL alu_rf5 got=%0h exp=beef", rf[5]); end
        total++; if (bus.regWrite !== 1'b0) begin bad++; $display("FAIL alu_we_drop got=%0h exp=0", bus.regWrite); end
        total++; if (bus.reg3 !== 3'd5) begin bad++; $display("FAIL alu_dest_hold got=%0h exp=5", bus.reg3); end
    endtask

    task automatic test_collision();
        bus.aluValid = 1'b1; bus.aluDest = 3'd2; bus.aluData = 16'h0011;
        bus.ldValid = 1'b1; bus.ldDest = 3'd3; bus.ldData = 16'h0022;
        tick();
        idle();
        total++; if ({bus.regWrite, bus.reg3, bus.dataToWrite} !== {1'b1, 3'd2, 16'h0011}) begin bad++; $display("FAIL col_alu got=%0h/%0h/%0h exp=1/2/11", bus.regWrite, bus.reg3, bus.dataToWrite); end
        total++; if (bus.fifoCount !== 2'd1) begin bad++; $display("FAIL col_count1 got=%0h exp=1", bus.fifoCount); end
        tick();
        total++; if ({bus.regWrite, bus.reg3, bus.dataToWrite} !== {1'b1, 3'd3, 16'h0022}) begin bad++; $display("FAIL col_ld got=%0h/%0h/%0h exp=1/3/22", bus.regWrite, bus.reg3, bus.dataToWrite); end
        total++; if (bus.fifoCount !== 2'd0) begin bad++; $display("FAIL col_count0 got=%0h exp=0", bus.fifoCount); end
        tick();
        total++; if (bus.regWrite !== 1'b0) begin bad++; $display("FAIL col_idle_we got=%0h exp=0", bus.regWrite); end
        total++; if (rf[3] !== 16'h0022) begin bad++; $display("FAIL col_rf3 got=%0h exp=22", rf[3]); end
    endtask

    task automatic test_starve();
        bus.aluValid = 1'b1; bus.aluDest = 3'd1; bus.aluData = 16'h0101;
        bus.ldValid = 1'b1; bus.ldDest = 3'd6; bus.ldData = 16'hA001;
        tick();
        total++; if ({bus.fifoCount, bus.ldReady} !== {2'd1, 1'b1}) begin bad++; $display("FAIL stv_e1 got=%0h/%0h exp=1/1", bus.fifoCount, bus.ldReady); end
        bus.ldDest = 3'd7; bus.ldData = 16'hA002;
        tick();
        total++; if ({bus.fifoCount, bus.ldReady} !== {2'd2, 1'b0}) begin bad++; $display("FAIL stv_full got=%0h/%0h exp=2/0", bus.fifoCount, bus.ldReady); end
        bus.ldDest = 3'd6; bus.ldData = 16'hA003;
        for (int c = 3; c <= 5; c++) begin
            tick();
            total++; if ({bus.regWrite, bus.reg3, bus.aluStall} !== {1'b1, 3'd1, (c == 5)}) begin bad++; $display("FAIL stv_win%0d got=%0h/%0h/%0h exp=1/1/%0h", c, bus.regWrite, bus.reg3, bus.aluStall, (c == 5)); end
            total++; if (bus.ldReady !== 1'b0) begin bad++; $display("FAIL stv_rdy%0d got=%0h exp=0", c, bus.ldReady); end
        end
        tick();
        total++; if ({bus.regWrite, bus.reg3, bus.dataToWrite} !== {1'b1, 3'd6, 16'hA001}) begin bad++; $display("FAIL stv_forced got=%0h/%0h/%0h exp=1/6/a001", bus.regWrite, bus.reg3, bus.dataToWrite); end
        total++; if ({bus.aluStall, bus.fifoCount} !== {1'b0, 2'd1}) begin bad++; $display("FAIL stv_after got=%0h/%0h exp=0/1", bus.aluStall, bus.fifoCount); end
        tick();
        total++; if ({bus.reg3, bus.dataToWrite, bus.fifoCount} !== {3'd1, 16'h0101, 2'd2}) begin bad++; $display("FAIL stv_e7 got=%0h/%0h/%0h exp=1/101/2", bus.reg3, bus.dataToWrite, bus.fifoCount); end
        idle();
        tick();
        total++; if ({bus.reg3, bus.dataToWrite} !== {3'd7, 16'hA002}) begin bad++; $display("FAIL stv_drainB got=%0h/%0h exp=7/a002", bus.reg3, bus.dataToWrite); end
        tick();
        total++; if ({bus.reg3, bus.dataToWrite, bus.fifoCount} !== {3'd6, 16'hA003, 2'd0}) begin bad++; $display("FAIL stv_drainC got=%0h/%0h/%0h exp=6/a003/0", bus.reg3, bus.dataToWrite, bus.fifoCount); end
        tick();
        total++; if (bus.regWrite !== 1'b0) begin bad++; $display("FAIL stv_idle got=%0h exp=0", bus.regWrite); end
    endtask

    task automatic test_scoreboard();
        bus.issueValid = 1'b1; bus.issueDest = 3'd4;
        tick();
        total++; if (bus.pending !== 8'h10) begin bad++; $display("FAIL sb_set got=%0h exp=10", bus.pending); end
        bus.aluValid = 1'b1; bus.aluDest = 3'd4; bus.aluData = 16'h4444;
        tick();
        total++; if (bus.pending !== 8'h10) begin bad++; $display("FAIL sb_set_wins got=%0h exp=10", bus.pending); end
        bus.issueDest = 3'd0;
        tick();
        total++; if (bus.pending !== 8'h01) begin bad++; $display("FAIL sb_clear got=%0h exp=01", bus.pending); end
        bus.issueValid = 1'b0; bus.aluDest = 3'd0; bus.aluData = 16'h0F0F;
        tick();
        idle();
        total++; if ({bus.regWrite, bus.reg3, bus.dataToWrite, bus.pending} !== {1'b1, 3'd0, 16'h0F0F, 8'h00}) begin bad++; $display("FAIL sb_r0 got=%0h/%0h/%0h/%0h exp=1/0/f0f/0", bus.regWrite, bus.reg3, bus.dataToWrite, bus.pending); end
        tick();
        total++; if (rf[0] !== 16'h0F0F) begin bad++; $display("FAIL sb_rf0 got=%0h exp=f0f", rf[0]); end
    endtask

    task automatic test_wrap_reset();
        logic [15:0] dat [5];
        dat[0] = 16'hC001; dat[1] = 16'hC0DE; dat[2] = 16'h5A5A; dat[3] = 16'h0FF0; dat[4] = 16'hFEED;
        for (int i = 0; i <= 5; i++) begin
            bus.ldValid = (i < 5);
            bus.ldDest = 3'((i + 2) % 8);
            bus.ldData = (i < 5) ? dat[i] : 16'h0;
            tick();
            if (i >= 1) begin
                total++; if ({bus.regWrite, bus.reg3, bus.dataToWrite} !== {1'b1, 3'((i + 1) % 8), dat[i - 1]}) begin bad++; $display("FAIL wrap%0d got=%0h/%0h/%0h exp=1/%0h/%0h", i, bus.regWrite, bus.reg3, bus.dataToWrite, (i + 1) % 8, dat[i - 1]); end
            end
            total++; if (bus.fifoCount !== ((i < 5) ? 2'd1 : 2'd0)) begin bad++; $display("FAIL wrap_cnt%0d got=%0h exp=%0h", i, bus.fifoCount, (i < 5) ? 1 : 0); end
        end
        bus.aluValid = 1'b1; bus.aluDest = 3'd7; bus.aluData = 16'h7777;
        bus.ldValid = 1'b1; bus.ldDest = 3'd2; bus.ldData = 16'hD005;
        bus.issueValid = 1'b1; bus.issueDest = 3'd3;
        tick();
        bus.issueValid = 1'b0;
        bus.ldData = 16'hD006;
        tick();
        total++; if ({bus.fifoCount, bus.regWrite, bus.pending} !== {2'd2, 1'b1, 8'h08}) begin bad++; $display("FAIL rst2_pre got=%0h/%0h/%0h exp=2/1/08", bus.fifoCount, bus.regWrite, bus.pending); end
        idle();
        resetN = 1'b0;
        #1;
        total++; if ({bus.regWrite, bus.fifoCount, bus.ldReady, bus.pending} !== {1'b0, 2'd0, 1'b1, 8'h00}) begin bad++; $display("FAIL rst2_async got=%0h/%0h/%0h/%0h exp=0/0/1/0", bus.regWrite, bus.fifoCount, bus.ldReady, bus.pending); end
        tick();
        resetN = 1'b1;
        tick();
        total++; if ({bus.regWrite, bus.fifoCount} !== {1'b0, 2'd0}) begin bad++; $display("FAIL rst2_release got=%0h/%0h exp=0/0", bus.regWrite, bus.fifoCount); end
        tick();
        total++; if (bus.regWrite !== 1'b0) begin bad++; $display("FAIL rst2_nowrite got=%0h exp=0", bus.regWrite); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        for (int r = 0; r < 8; r++) rf[r] = '0;
        test_reset();
        test_alu();
        test_collision();
        test_starve();
        test_scoreboard();
        test_wrap_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
